// File: rtl/serial_mag_comp_if.sv
// serial_mag_comp_if: bundles the serial comparator's operand stream and result signals
//   start, bit_valid, a, b : driven by the master (operand source)
//   busy, done, l1, l2, l3 : driven by the slave (comparator)
//   bit_cnt                : bits consumed so far, driven by the slave
interface serial_mag_comp_if #(parameter int WIDTH = 8);
    logic                     start;
    logic                     bit_valid;
    logic                     a;
    logic                     b;
    logic                     busy;
    logic                     done;
    logic                     l1;
    logic                     l2;
    logic                     l3;
    logic [$clog2(WIDTH)-1:0] bit_cnt;
    modport master (output start, bit_valid, a, b, input busy, done, l1, l2, l3, bit_cnt);
    modport slave (input start, bit_valid, a, b, output busy, done, l1, l2, l3, bit_cnt);
endinterface

// File: rtl/serial_mag_comp.sv
// serial_mag_comp: LSB-first bit-serial magnitude comparator (l1=a<b, l2=a>b, l3=a==b)
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_mag_comp_if.slave (start, bit_valid, a, b in; busy, done, l1-l3, bit_cnt out)
// Optional: define SIGNED_CMP_EN to treat operands as two's complement.
module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_mag_comp_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_n;
    logic          lt, gt, lt_n, gt_n;
    logic          take, last, flip;
    logic [CW-1:0] cnt;
    logic          l1, l2, l3;

    assign take = state == SHIFT && bus.bit_valid;
    assign last = cnt == CW'(WIDTH - 1);

    // The sign bit ranks opposite to magnitude bits: a 1 there means smaller.
`ifdef SIGNED_CMP_EN
    assign flip = last;
`else
    assign flip = 1'b0;
`endif

    // A differing bit is more significant than anything seen so far, so it overrides.
    assign lt_n = (bus.a ^ bus.b) ? bus.b ^ flip : lt;
    assign gt_n = (bus.a ^ bus.b) ? bus.a ^ flip : gt;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? SHIFT : IDLE;
            SHIFT:   state_n = (take && last) ? DONE : SHIFT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lt    <= 1'b0;
            gt    <= 1'b0;
            cnt   <= '0;
            l1    <= 1'b0;
            l2    <= 1'b0;
            l3    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.start) begin
                lt  <= 1'b0;
                gt  <= 1'b0;
                cnt <= '0;
            end
            if (take) begin
                lt  <= lt_n;
                gt  <= gt_n;
                cnt <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    l1 <= lt_n;
                    l2 <= gt_n;
                    l3 <= ~(lt_n | gt_n);
                end
            end
        end
    end

    assign bus.busy    = state == SHIFT;
    assign bus.done    = state == DONE;
    assign bus.l1      = l1;
    assign bus.l2      = l2;
    assign bus.l3      = l3;
    assign bus.bit_cnt = cnt;
endmodule

// File: doc/serial_mag_comp.md
# serial_mag_comp

LSB-first bit-serial magnitude comparator for two WIDTH-bit operands. Complements the MSB-first cascaded comparator slice: there, the more significant result wins by propagating downward; here, operands arrive least-significant bit first and each newer (more significant) differing bit overrides the running verdict. Used where operands stream in from shift registers or serial links. Produces the same l1 (a<b), l2 (a>b), l3 (a==b) flag set as the combinational comparator slices.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new comparison; honoured only in IDLE
- bit_valid  input  1  a/b carry a valid bit pair this cycle
- a  input  1  serial operand A bit, LSB first
- b  input  1  serial operand B bit, LSB first
- busy  output  1  high in SHIFT state
- done  output  1  one-cycle pulse when l1/l2/l3 become valid
- l1  output  1  registered result a<b
- l2  output  1  registered result a>b
- l3  output  1  registered result a==b
- bit_cnt  output  $clog2(WIDTH)  bits consumed so far in current comparison

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 → SHIFT; clear bit_cnt and internal lt/gt trackers. bit_valid ignored in IDLE, including the start cycle.
- SHIFT: each cycle with bit_valid=1 consumes (a,b):
  - a=0,b=1 → lt=1, gt=0
  - a=1,b=0 → lt=0, gt=1
  - a==b → lt/gt hold
  - bit_cnt increments; bit_valid=0 stalls with no state change.
- On consuming bit index WIDTH-1 → DONE; l1=lt', l2=gt', l3=~lt'&~gt' (post-update values) registered on the same edge.
- DONE: done=1 for exactly this cycle → IDLE unconditionally; start in DONE ignored.
- l1/l2/l3 hold their values from DONE until the next comparison's DONE; they are not cleared by start.
- start while busy: ignored, no restart.
- Exactly one of l1/l2/l3 is high after any completed comparison.

## Timing
- Reset values: state=IDLE, busy=0, done=0, l1=0, l2=0, l3=0, bit_cnt=0, trackers cleared.
- rst has priority over every other input; reset in SHIFT or DONE aborts with no done pulse.
- Minimum latency: start at cycle 0, bits at cycles 1..WIDTH, done high at cycle WIDTH+1, l1/l2/l3 valid from that cycle.
- busy high from cycle after start through the cycle the last bit is consumed; low in DONE.
- bit_cnt wraps to 0 on transition to DONE.
- Back-to-back: earliest next start is the cycle after DONE (IDLE).

## Configuration
- SIGNED_CMP_EN defined: operands are two's complement; at bit index WIDTH-1 the sign bit takes inverted precedence (a=1,b=0 → lt=1,gt=0; a=0,b=1 → gt=1,lt=0; equal → hold).
- SIGNED_CMP_EN undefined: all bits, including index WIDTH-1, use the unsigned rule. Ports identical either way.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C streamed back-to-back → done at cycle 9; l2=1, l1=0, l3=0.
- A=0xFF, B=0xFF → l3=1, l1=l2=0; A=0x01, B=0x80 → l1=1 (MSB overrides earlier gt).
- A=0x3C, B=0x5A with bit_valid low for 3 random cycles mid-stream → same verdict (l1=1), done delayed 3 cycles, bit_cnt frozen during gaps.
- Assert rst after 4 bits → next cycle busy=0, done=0, l1=l2=l3=0, bit_cnt=0; no done pulse; new comparison 0x10 vs 0x10 → l3=1.
- start pulsed during SHIFT and in DONE → ignored; comparison completes unchanged; exactly one done pulse.
- A=0x80, B=0x01: with SIGNED_CMP_EN → l1=1; without → l2=1.
